ccu_snoop_broadcast: RTL

//  Snoop fan-out/fan-in stage sitting directly downstream of ccu_ctrl_wr_snoop.
//  - Takes one snoop request (address, ACSNOOP, ACPROT) plus a target mask of

---
 rtl/ccu_snoop_broadcast.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ccu_snoop_broadcast.sv
// ccu_snoop_broadcast
// Snoop fan-out/fan-in stage behind ccu_ctrl_wr_snoop. A single snoop request
// is broadcast on the AC channel of every targeted cached master. The stage
// collects each CR response and returns one merged CRRESP together with a
// per-master DataTransfer mask, so the controller knows whose CD data to drain.
// Only one transaction is in flight at a time.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_*               incoming snoop request (valid/ready, addr, snoop, prot, target)
//   ac_valid_o/ready_i  per-master AC handshake
//   ac_addr/snoop/prot  shared registered AC payload
//   cr_valid_i/ready_o  per-master CR handshake, cr_resp_i holds master i at [5*i+:5]
//   rsp_valid_o/ready_i merged response handshake
//   rsp_o               OR of collected CRRESP values
//   rsp_data_mask_o     bit i set when master i answered with DataTransfer=1
module ccu_snoop_broadcast #(
   parameter int NumMst    = 4,
   parameter int AddrWidth = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic [3:0]             req_snoop_i,
   input  logic [2:0]             req_prot_i,
   input  logic [NumMst-1:0]      req_target_i,
   output logic [NumMst-1:0]      ac_valid_o,
   input  logic [NumMst-1:0]      ac_ready_i,
   output logic [AddrWidth-1:0]   ac_addr_o,
   output logic [3:0]             ac_snoop_o,
   output logic [2:0]             ac_prot_o,
   input  logic [NumMst-1:0]      cr_valid_i,
   output logic [NumMst-1:0]      cr_ready_o,
   input  logic [5*NumMst-1:0]    cr_resp_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [4:0]             rsp_o,
   output logic [NumMst-1:0]      rsp_data_mask_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [NumMst-1:0]      ac_pend_q, ac_pend_d;
   logic [NumMst-1:0]      cr_pend_q, cr_pend_d;
   logic [NumMst-1:0]      mask_q, mask_d;
   logic [4:0]             rsp_q, rsp_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [3:0]             snoop_q, snoop_d;
   logic [2:0]             prot_q, prot_d;
   logic [NumMst-1:0]      ac_hs;
   logic [NumMst-1:0]      cr_hs;

   // Next-state and handshake logic. All handshake outputs come from registered
   // state only, so there is no combinational path from any input to
   // req_ready_o, ac_valid_o or rsp_valid_o.
   always_comb begin
      state_d     = state_q;
      ac_pend_d   = ac_pend_q;
      cr_pend_d   = cr_pend_q;
      mask_d      = mask_q;
      rsp_d       = rsp_q;
      addr_d      = addr_q;
      snoop_d     = snoop_q;
      prot_d      = prot_q;
      ac_hs       = '0;
      cr_hs       = '0;
      req_ready_o = 1'b0;
      ac_valid_o  = '0;
      cr_ready_o  = '0;
      rsp_valid_o = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               addr_d    = req_addr_i;
               snoop_d   = req_snoop_i;
               prot_d    = req_prot_i;
               ac_pend_d = req_target_i;
               cr_pend_d = '0;
               rsp_d     = '0;
               mask_d    = '0;
               // An empty target set has nothing to collect, answer at once.
               state_d   = (req_target_i != '0) ? BUSY : RESP;
            end
         end

         BUSY: begin
            ac_valid_o = ac_pend_q;
            cr_ready_o = cr_pend_q;
            ac_hs      = ac_pend_q & ac_ready_i;
            cr_hs      = cr_pend_q & cr_valid_i;
            // A master moves from "AC owed" to "CR owed" on its AC handshake,
            // so a CR can never be accepted before the matching AC.
            ac_pend_d  = ac_pend_q & ~ac_hs;
            cr_pend_d  = (cr_pend_q & ~cr_hs) | ac_hs;
            for (int i = 0; i < NumMst; i++) begin
               if (cr_hs[i]) begin
                  rsp_d     = rsp_d | cr_resp_i[5*i +: 5];
                  mask_d[i] = cr_resp_i[5*i];
               end
            end
            if (ac_pend_d == '0 && cr_pend_d == '0) begin
               state_d = RESP;
            end
         end

         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and payload registers; reset abandons any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ac_pend_q <= '0;
         cr_pend_q <= '0;
         mask_q    <= '0;
         rsp_q     <= '0;
         addr_q    <= '0;
         snoop_q   <= '0;
         prot_q    <= '0;
      end else begin
         state_q   <= state_d;
         ac_pend_q <= ac_pend_d;
         cr_pend_q <= cr_pend_d;
         mask_q    <= mask_d;
         rsp_q     <= rsp_d;
         addr_q    <= addr_d;
         snoop_q   <= snoop_d;
         prot_q    <= prot_d;
      end
   end

   assign ac_addr_o       = addr_q;
   assign ac_snoop_o      = snoop_q;
   assign ac_prot_o       = prot_q;
   assign rsp_o           = rsp_q;
   assign rsp_data_mask_o = mask_q;

endmodule
